// File: rtl/verificador_senha.sv
// verificador_senha: checks a keypad code packet against the stored master code.
// This module drives the door-unlock pulse, the rejection pulse and the
// brute-force lockout.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   enable         0 forces IDLE and zeroes the timer; the failure count is kept
//   digitos_value  code packet from the keypad decoder (digits[0] = newest, pad = 4'hF)
//   digitos_valid  one-cycle strobe qualifying digitos_value (accepted only in IDLE)
//   senha_cfg      stored master code, same packet format, read only in CHECK
//   abre           unlock, high for T_ABERTO cycles after a matching code
//   erro           rejection, high for T_ERRO cycles after a wrong or malformed code
//   bloqueado      high for T_BLOQ cycles after MAX_TENT consecutive failures
//   tentativas     consecutive-failure count, saturates at MAX_TENT
//   estado         current FSM state (debug/observability)
//
// Handshake: digitos_valid is a single-cycle strobe with no ready. The packet
// is captured only when the strobe is seen in IDLE. A strobe seen in any other
// state is dropped, and nothing is queued.

package verificador_senha_pkg;
    typedef logic [19:0][3:0] senhaPac_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        ABERTO   = 3'd2,
        ERRO     = 3'd3,
        BLOQUEIO = 3'd4
    } estado_t;
endpackage

module verificador_senha
    import verificador_senha_pkg::*;
#(
    parameter int T_ABERTO = 100,
    parameter int T_ERRO   = 10,
    parameter int T_BLOQ   = 500,
    parameter int MAX_TENT = 3,
    parameter int MIN_DIG  = 4,
    parameter int MAX_DIG  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  senhaPac_t  digitos_value,
    input  logic       digitos_valid,
    input  senhaPac_t  senha_cfg,
    output logic       abre,
    output logic       erro,
    output logic       bloqueado,
    output logic [2:0] tentativas,
    output estado_t    estado
);

    localparam int T_MAX1 = (T_ABERTO > T_ERRO) ? T_ABERTO : T_ERRO;
    localparam int T_MAX  = (T_MAX1 > T_BLOQ) ? T_MAX1 : T_BLOQ;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LOAD_ABERTO = TW'(T_ABERTO);
    localparam logic [TW-1:0] LOAD_ERRO   = TW'(T_ERRO);
    localparam logic [TW-1:0] LOAD_BLOQ   = TW'(T_BLOQ);
    localparam logic [2:0]    MAX_T       = 3'(MAX_TENT);
    localparam logic [4:0]    MIN_L       = 5'(MIN_DIG);
    localparam logic [4:0]    MAX_L       = 5'(MAX_DIG);

    estado_t        state, state_n;
    logic [TW-1:0]  timer, timer_n;
    logic [2:0]     tent_n;
    senhaPac_t      cap, cap_n;

    // Packet classification on the captured packet
    logic       all_e, all_b;
    logic [4:0] len;
    logic       run, stray, bad_digit;
    logic       malformed, match;

    always_comb begin
        all_e     = 1'b1;
        all_b     = 1'b1;
        len       = 5'd0;
        run       = 1'b1;
        stray     = 1'b0;
        bad_digit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cap[i] != 4'hE) all_e = 1'b0;
            if (cap[i] != 4'hB) all_b = 1'b0;
            if (cap[i] != 4'hF) begin
                // Digits after the first pad slot make the code ambiguous.
                if (run) len = len + 5'd1;
                else     stray = 1'b1;
                if (cap[i] >= 4'hA && cap[i] <= 4'hE) bad_digit = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
        malformed = stray || bad_digit || (len < MIN_L) || (len > MAX_L);
        // Pad slots are compared too, so the lengths must agree.
        match     = (cap == senha_cfg);
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        tent_n  = tentativas;
        cap_n   = cap;
        if (!enable) begin
            // The failure count survives, so toggling enable cannot reset a lockout count.
            state_n = IDLE;
            timer_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (digitos_valid) begin
                        cap_n   = digitos_value;
                        state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (all_e || all_b) begin
                        state_n = IDLE;
                    end else if (!malformed && match) begin
                        state_n = ABERTO;
                        tent_n  = 3'd0;
                        timer_n = LOAD_ABERTO;
                    end else begin
                        tent_n = (tentativas >= MAX_T) ? MAX_T : tentativas + 3'd1;
                        if (tent_n == MAX_T) begin
                            state_n = BLOQUEIO;
                            timer_n = LOAD_BLOQ;
                        end else begin
                            state_n = ERRO;
                            timer_n = LOAD_ERRO;
                        end
                    end
                end
                ABERTO, ERRO, BLOQUEIO: begin
                    if (timer <= TW'(1)) begin
                        state_n = IDLE;
                        timer_n = '0;
                        if (state == BLOQUEIO) tent_n = 3'd0;
                    end else begin
                        timer_n = timer - TW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            tentativas <= 3'd0;
            cap        <= '1;
            abre       <= 1'b0;
            erro       <= 1'b0;
            bloqueado  <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            tentativas <= tent_n;
            cap        <= cap_n;
            // Outputs are registered from the next state, so they line up with the state.
            abre       <= (state_n == ABERTO);
            erro       <= (state_n == ERRO);
            bloqueado  <= (state_n == BLOQUEIO);
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_verificador_senha.sv
module tb_verificador_senha;
    import verificador_senha_pkg::*;

    logic       clk;
    logic       rst;
    logic       enable;
    senhaPac_t  digitos_value;
    logic       digitos_valid;
    senhaPac_t  senha_cfg;
    logic       abre;
    logic       erro;
    logic       bloqueado;
    logic [2:0] tentativas;
    estado_t    estado;

    int n_cmp  = 0;
    int n_fail = 0;

    verificador_senha dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .senha_cfg     (senha_cfg),
        .abre          (abre),
        .erro          (erro),
        .bloqueado     (bloqueado),
        .tentativas    (tentativas),
        .estado        (estado)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // packet builder: lowest nibble of d is digits[0]; slots >= len are 4'hF
    function automatic senhaPac_t mk(input int len, input logic [79:0] d);
        senhaPac_t r;
        for (int i = 0; i < 20; i++) r[i] = (i < len) ? d[i*4 +: 4] : 4'hF;
        return r;
    endfunction

    // driver: one-cycle strobe; returns at the negedge where the DUT is in CHECK
    task automatic send(input senhaPac_t p);
        @(negedge clk);
        digitos_value = p;
        digitos_valid = 1'b1;
        @(negedge clk);
        digitos_valid = 1'b0;
    endtask

    // measure a pulse: sel 0=abre 1=erro 2=bloqueado; call right after send
    task automatic measure(input int sel, output int first_hi, output int width,
                           output int others, output int tent_first);
        logic s;
        first_hi = 0; width = 0; others = 0; tent_first = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            case (sel)
                0:       s = abre;
                1:       s = erro;
                default: s = bloqueado;
            endcase
            if (c == 0) begin
                first_hi   = int'(s);
                tent_first = int'(tentativas);
            end
            if (sel != 0 && abre)      others++;
            if (sel != 1 && erro)      others++;
            if (sel != 2 && bloqueado) others++;
            if (s) width++;
            else if (width > 0) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; digitos_valid = 1'b0;
        digitos_value = '1; senha_cfg = mk(4, 80'h1234);
        repeat (3) @(negedge clk);
        n_cmp++; if (abre !== 1'b0) begin n_fail++; $display("FAIL reset_abre: got %0b expected 0", abre); end
        n_cmp++; if (erro !== 1'b0) begin n_fail++; $display("FAIL reset_erro: got %0b expected 0", erro); end
        n_cmp++; if (bloqueado !== 1'b0) begin n_fail++; $display("FAIL reset_bloq: got %0b expected 0", bloqueado); end
        n_cmp++; if (tentativas !== 3'd0) begin n_fail++; $display("FAIL reset_tent: got %0d expected 0", tentativas); end
        n_cmp++; if (estado !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", estado); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_correct;
        int f, w, o, t;
        senha_cfg = mk(4, 80'h1234);
        send(mk(4, 80'h1234));
        n_cmp++; if (estado !== CHECK) begin n_fail++; $display("FAIL ok_check_state: got %0d expected 1", estado); end
        n_cmp++; if (abre !== 1'b0) begin n_fail++; $display("FAIL ok_abre_in_check: got %0b expected 0", abre); end
        measure(0, f, w, o, t);
        n_cmp++; if (f !== 1) begin n_fail++; $display("FAIL ok_latency: got %0d expected 1", f); end
        n_cmp++; if (w !== 100) begin n_fail++; $display("FAIL ok_width: got %0d expected 100", w); end
        n_cmp++; if (o !== 0) begin n_fail++; $display("FAIL ok_other_outputs: got %0d expected 0", o); end
        n_cmp++; if (t !== 0) begin n_fail++; $display("FAIL ok_tent: got %0d expected 0", t); end
    endtask

    task automatic test_wrong_then_right;
        int f, w, o, t;
        for (int k = 1; k <= 2; k++) begin
            send(mk(4, 80'h1235));
            measure(1, f, w, o, t);
            n_cmp++; if (f !== 1) begin n_fail++; $display("FAIL wr_latency%0d: got %0d expected 1", k, f); end
            n_cmp++; if (w !== 10) begin n_fail++; $display("FAIL wr_width%0d: got %0d expected 10", k, w); end
            n_cmp++; if (t !== k) begin n_fail++; $display("FAIL wr_tent%0d: got %0d expected %0d", k, t, k); end
            n_cmp++; if (o !== 0) begin n_fail++; $display("FAIL wr_other%0d: got %0d expected 0", k, o); end
        end
        send(mk(4, 80'h1234));
        measure(0, f, w, o, t);
        n_cmp++; if (w !== 100) begin n_fail++; $display("FAIL wr_open_width: got %0d expected 100", w); end
        n_cmp++; if (t !== 0) begin n_fail++; $display("FAIL wr_open_tent: got %0d expected 0", t); end
    endtask

    task automatic test_lockout;
        int f, w, o, t, cnt, abre_seen;
        for (int k = 1; k <= 2; k++) begin
            send(mk(4, 80'h9999));
            measure(1, f, w, o, t);
        end
        send(mk(4, 80'h9999));
        digitos_value = mk(4, 80'h1234);
        cnt = 0; abre_seen = 0; t = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (abre) abre_seen = 1;
            if (c == 0) t = int'(tentativas);
            if (bloqueado) cnt++;
            else if (cnt > 0) break;
            digitos_valid = (cnt == 10);
        end
        digitos_valid = 1'b0;
        n_cmp++; if (t !== 3) begin n_fail++; $display("FAIL lk_tent: got %0d expected 3", t); end
        n_cmp++; if (cnt !== 500) begin n_fail++; $display("FAIL lk_width: got %0d expected 500", cnt); end
        n_cmp++; if (abre_seen !== 0) begin n_fail++; $display("FAIL lk_ignored_open: got %0d expected 0", abre_seen); end
        n_cmp++; if (tentativas !== 3'd0) begin n_fail++; $display("FAIL lk_tent_after: got %0d expected 0", tentativas); end
        send(mk(4, 80'h1234));
        measure(0, f, w, o, t);
        n_cmp++; if (w !== 100) begin n_fail++; $display("FAIL lk_open_after: got %0d expected 100", w); end
    endtask

    task automatic test_special;
        int f, w, o, t, seen;
        senhaPac_t p;
        send(mk(4, 80'h4321));
        measure(1, f, w, o, t);
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? {20{4'hE}} : {20{4'hB}};
            send(p);
            @(negedge clk);
            n_cmp++; if (estado !== IDLE) begin n_fail++; $display("FAIL sp_state%0d: got %0d expected 0", k, estado); end
            seen = 0;
            repeat (4) begin
                if (abre || erro || bloqueado) seen++;
                @(negedge clk);
            end
            n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL sp_pulse%0d: got %0d expected 0", k, seen); end
            n_cmp++; if (tentativas !== 3'd1) begin n_fail++; $display("FAIL sp_tent%0d: got %0d expected 1", k, tentativas); end
        end
    endtask

    task automatic test_malformed;
        int f, w, o, t;
        senhaPac_t bad[4];
        bad[0] = mk(3, 80'h123);
        bad[1] = mk(13, 80'h1234567890123);
        bad[2] = mk(4, 80'h123A);
        bad[3] = mk(4, 80'h1234);
        bad[3][10] = 4'h5;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                send(mk(4, 80'h1234));
                measure(0, f, w, o, t);
            end
            send(bad[k]);
            measure(1, f, w, o, t);
            n_cmp++; if (w !== 10) begin n_fail++; $display("FAIL mf_width%0d: got %0d expected 10", k, w); end
            n_cmp++; if (t !== (k % 2) + 1) begin n_fail++; $display("FAIL mf_tent%0d: got %0d expected %0d", k, t, (k % 2) + 1); end
        end
        // 12 digits is the longest accepted code
        senha_cfg = mk(12, 80'h123456789012);
        send(mk(12, 80'h123456789012));
        measure(0, f, w, o, t);
        n_cmp++; if (w !== 100) begin n_fail++; $display("FAIL mf_max_len_open: got %0d expected 100", w); end
        n_cmp++; if (t !== 0) begin n_fail++; $display("FAIL mf_max_len_tent: got %0d expected 0", t); end
        senha_cfg = mk(4, 80'h1234);
    endtask

    task automatic test_reset_enable;
        int f, w, o, t;
        send(mk(4, 80'h1234));
        repeat (5) @(negedge clk);
        n_cmp++; if (abre !== 1'b1) begin n_fail++; $display("FAIL re_abre_before: got %0b expected 1", abre); end
        rst = 1'b1;
        #1;
        n_cmp++; if (abre !== 1'b0) begin n_fail++; $display("FAIL re_async_abre: got %0b expected 0", abre); end
        n_cmp++; if (estado !== IDLE) begin n_fail++; $display("FAIL re_async_state: got %0d expected 0", estado); end
        @(negedge clk);
        rst = 1'b0;
        send(mk(4, 80'h1111));
        measure(1, f, w, o, t);
        send(mk(4, 80'h1111));
        @(negedge clk);
        n_cmp++; if (tentativas !== 3'd2) begin n_fail++; $display("FAIL en_tent_in_erro: got %0d expected 2", tentativas); end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (erro !== 1'b0) begin n_fail++; $display("FAIL en_erro_drop: got %0b expected 0", erro); end
        n_cmp++; if (estado !== IDLE) begin n_fail++; $display("FAIL en_state: got %0d expected 0", estado); end
        n_cmp++; if (tentativas !== 3'd2) begin n_fail++; $display("FAIL en_tent_kept: got %0d expected 2", tentativas); end
        enable = 1'b1;
        send(mk(4, 80'h1111));
        @(negedge clk);
        n_cmp++; if (bloqueado !== 1'b1) begin n_fail++; $display("FAIL en_bloq: got %0b expected 1", bloqueado); end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (bloqueado !== 1'b0) begin n_fail++; $display("FAIL en_bloq_drop: got %0b expected 0", bloqueado); end
        n_cmp++; if (tentativas !== 3'd3) begin n_fail++; $display("FAIL en_bloq_tent: got %0d expected 3", tentativas); end
        enable = 1'b1;
        send(mk(4, 80'h1111));
        @(negedge clk);
        n_cmp++; if (bloqueado !== 1'b1) begin n_fail++; $display("FAIL en_rebloq: got %0b expected 1", bloqueado); end
        rst = 1'b1;
        #1;
        n_cmp++; if (tentativas !== 3'd0) begin n_fail++; $display("FAIL re_tent_cleared: got %0d expected 0", tentativas); end
        n_cmp++; if (bloqueado !== 1'b0) begin n_fail++; $display("FAIL re_bloq_cleared: got %0b expected 0", bloqueado); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_correct;
        test_wrong_then_right;
        test_lockout;
        test_special;
        test_malformed;
        test_reset_enable;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
